// File: rtl/regbank_pkg.sv
// regbank_mp shared types, defaults and byte-merge helper.
// Imported by the register bank top and its clear sequencer.
package regbank_pkg;

   typedef enum logic {
      CLEAR,
      IDLE
   } state_t;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_ADDR_W = 5;
   // Widest register the merge helper covers; narrower banks zero-extend.
   localparam int MAX_W      = 128;

   function automatic logic [MAX_W-1:0] byte_merge(
      input logic [MAX_W-1:0]   old_v,
      input logic [MAX_W-1:0]   nw_v,
      input logic [MAX_W/8-1:0] be
   );
      logic [MAX_W-1:0] r;
      r = old_v;
      for (int b = 0; b < MAX_W/8; b++) begin
         if (be[b]) r[8*b +: 8] = nw_v[8*b +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/regbank_clr_seq.sv
// Clear sequencer: walks every entry once after reset or on request.
// busy/clr_we stay high while the walk is in progress.
module regbank_clr_seq
   import regbank_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              clr_req,
   output logic              busy,
   output logic              clr_we,
   output logic [ADDR_W-1:0] clr_idx
);

   localparam logic [ADDR_W-1:0] LAST = '1;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [ADDR_W-1:0] r_idx;
   logic [ADDR_W-1:0] w_idx_nxt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= CLEAR;
         r_idx   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      unique case (r_state)
         CLEAR: begin
            w_idx_nxt = r_idx + ADDR_W'(1);
            if (r_idx == LAST) w_state_nxt = IDLE;
         end
         IDLE: begin
            if (clr_req) begin
               w_state_nxt = CLEAR;
               w_idx_nxt   = '0;
            end
         end
         default: w_state_nxt = CLEAR;
      endcase
   end

   assign busy    = (r_state == CLEAR);
   assign clr_we  = busy;
   assign clr_idx = r_idx;

endmodule

// File: rtl/regbank_mp.sv
// Parametrised multi-read-port register bank with byte-enabled write,
// optional bypass, optional zero register and a hardware clear walk.
module regbank_mp
   import regbank_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int NRD      = 2,
   parameter int BYPASS   = 1,
   parameter int ZERO_REG = 1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [NRD*ADDR_W-1:0] rd_addr,
   output logic [NRD*DATA_W-1:0] rd_data,
   input  logic                  wr_en,
   input  logic [ADDR_W-1:0]     wr_addr,
   input  logic [DATA_W-1:0]     wr_data,
   input  logic [DATA_W/8-1:0]   wr_be,
   output logic                  wr_ack,
   input  logic                  clr_req,
   output logic                  busy
);

   localparam int DEPTH = 2**ADDR_W;

   logic [DATA_W-1:0] r_mem [DEPTH];

   logic              w_busy;
   logic              w_clr_we;
   logic [ADDR_W-1:0] w_clr_idx;
   logic [DATA_W-1:0] w_wr_merge;

   regbank_clr_seq #(
      .ADDR_W (ADDR_W)
   ) u_clr_seq (
      .clk     (clk),
      .reset_n (reset_n),
      .clr_req (clr_req),
      .busy    (w_busy),
      .clr_we  (w_clr_we),
      .clr_idx (w_clr_idx)
   );

   assign busy   = w_busy;
   assign wr_ack = wr_en & ~w_busy & ~clr_req;

   assign w_wr_merge = DATA_W'(byte_merge(
      MAX_W'(r_mem[wr_addr]),
      MAX_W'(wr_data),
      (MAX_W/8)'(wr_be)));

   // Storage has no reset; the clear walk owns the write port while busy.
   always_ff @(posedge clk) begin
      if (w_clr_we)    r_mem[w_clr_idx] <= '0;
      else if (wr_ack) r_mem[wr_addr]   <= w_wr_merge;
   end

   for (genvar g = 0; g < NRD; g++) begin : g_rd
      logic [ADDR_W-1:0] w_ra;
      logic [DATA_W-1:0] w_rd;

      assign w_ra = rd_addr[g*ADDR_W +: ADDR_W];

      always_comb begin
         w_rd = r_mem[w_ra];
         if (ZERO_REG != 0 && w_ra == '0)
            w_rd = '0;
         else if (w_busy)
            w_rd = '0;
         else if (BYPASS != 0 && wr_ack && wr_addr == w_ra)
            w_rd = w_wr_merge;
      end

      assign rd_data[g*DATA_W +: DATA_W] = w_rd;
   end

endmodule

// File: tb/tb_regbank_mp.sv
// Directed self-checking bench for regbank_mp: default, no-bypass
// and narrow 4-port configurations driven side by side.
module tb_regbank_mp;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_n;
   logic [9:0]  rd_addr;
   logic [63:0] rd_data;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic [3:0]  wr_be;
   logic        wr_ack;
   logic        clr_req;
   logic        busy;

   logic [63:0] nb_rd_data;
   logic        nb_wr_ack;
   logic        nb_busy;

   logic [11:0] s_rd_addr;
   logic [63:0] s_rd_data;
   logic        s_wr_en;
   logic [2:0]  s_wr_addr;
   logic [15:0] s_wr_data;
   logic [1:0]  s_wr_be;
   logic        s_wr_ack;
   logic        s_clr_req;
   logic        s_busy;

   regbank_mp u_dut (
      .clk     (clk),
      .reset_n (reset_n),
      .rd_addr (rd_addr),
      .rd_data (rd_data),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .wr_be   (wr_be),
      .wr_ack  (wr_ack),
      .clr_req (clr_req),
      .busy    (busy)
   );

   regbank_mp #(
      .BYPASS (0)
   ) u_nb (
      .clk     (clk),
      .reset_n (reset_n),
      .rd_addr (rd_addr),
      .rd_data (nb_rd_data),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .wr_be   (wr_be),
      .wr_ack  (nb_wr_ack),
      .clr_req (clr_req),
      .busy    (nb_busy)
   );

   regbank_mp #(
      .DATA_W (16),
      .ADDR_W (3),
      .NRD    (4)
   ) u_sw (
      .clk     (clk),
      .reset_n (reset_n),
      .rd_addr (s_rd_addr),
      .rd_data (s_rd_data),
      .wr_en   (s_wr_en),
      .wr_addr (s_wr_addr),
      .wr_data (s_wr_data),
      .wr_be   (s_wr_be),
      .wr_ack  (s_wr_ack),
      .clr_req (s_clr_req),
      .busy    (s_busy)
   );

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h exp %0h", tag, got, exp);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int cnt;
      reset_n   = 1'b0;
      wr_en     = 1'b1;
      wr_addr   = 5'd3;
      wr_data   = 32'h55;
      wr_be     = 4'hf;
      rd_addr   = {5'd3, 5'd3};
      clr_req   = 1'b0;
      s_rd_addr = '0;
      s_wr_en   = 1'b0;
      s_wr_addr = '0;
      s_wr_data = '0;
      s_wr_be   = '0;
      s_clr_req = 1'b0;

      tick;
      tick;
      chk("rst_busy", 64'(busy), 64'd1);
      chk("rst_ack", 64'(wr_ack), 64'd0);
      chk("rst_rd", rd_data, 64'd0);
      chk("rst_sbusy", 64'(s_busy), 64'd1);

      reset_n = 1'b1;
      #1;
      for (int c = 0; c < 32; c++) begin
         chk("clr_busy", 64'(busy), 64'd1);
         chk("clr_ack", 64'(wr_ack), 64'd0);
         chk("clr_rd", rd_data, 64'd0);
         if (c < 8) chk("sw_busy", 64'(s_busy), 64'd1);
         else if (c == 8) chk("sw_done", 64'(s_busy), 64'd0);
         tick;
         #1;
      end
      chk("clr_end_busy", 64'(busy), 64'd0);
      chk("clr_end_ack", 64'(wr_ack), 64'd1);

      for (int k = 0; k < 32; k++) begin
         wr_addr = 5'(k);
         wr_data = 32'(10 * k);
         #1;
         chk("fill_ack", 64'(wr_ack), 64'd1);
         tick;
      end
      wr_en = 1'b0;
      for (int k = 0; k < 31; k++) begin
         rd_addr = {5'(k + 1), 5'(k)};
         #1;
         chk("fill_p0", 64'(rd_data[31:0]), (k == 0) ? 64'd0 : 64'(10 * k));
         chk("fill_p1", 64'(rd_data[63:32]), 64'(10 * (k + 1)));
      end

      for (int k = 0; k < 8; k++) begin
         s_wr_en   = 1'b1;
         s_wr_addr = 3'(k);
         s_wr_data = 16'(16'h1000 + k * 16'h0101);
         s_wr_be   = 2'b11;
         tick;
      end
      s_wr_en   = 1'b0;
      s_rd_addr = {3'd7, 3'd0, 3'd6, 3'd1};
      #1;
      chk("sw_rd4", s_rd_data, {16'h1707, 16'h0000, 16'h1606, 16'h1101});
      s_rd_addr = {3'd3, 3'd5, 3'd2, 3'd2};
      #1;
      chk("sw_alias", s_rd_data, {16'h1303, 16'h1505, 16'h1202, 16'h1202});

      wr_en   = 1'b1;
      wr_addr = 5'd5;
      wr_data = 32'h11223344;
      wr_be   = 4'hf;
      tick;
      wr_data = 32'hAABBCCDD;
      wr_be   = 4'b0101;
      tick;
      wr_en   = 1'b0;
      rd_addr = {5'd5, 5'd5};
      #1;
      chk("be_merge", 64'(rd_data[31:0]), 64'h11BB33DD);

      rd_addr = {5'd0, 5'd7};
      wr_en   = 1'b1;
      wr_addr = 5'd7;
      wr_data = 32'hDEADBEEF;
      wr_be   = 4'hf;
      #1;
      chk("byp_full", 64'(rd_data[31:0]), 64'hDEADBEEF);
      chk("nobyp_old", 64'(nb_rd_data[31:0]), 64'd70);
      tick;
      wr_data = 32'h12345678;
      wr_be   = 4'b0011;
      rd_addr = {5'd7, 5'd7};
      #1;
      chk("byp_part", 64'(rd_data[63:32]), 64'hDEAD5678);
      chk("nobyp_part", 64'(nb_rd_data[63:32]), 64'hDEADBEEF);
      tick;
      wr_en = 1'b0;
      #1;
      chk("wr_part", 64'(rd_data[31:0]), 64'hDEAD5678);

      wr_en   = 1'b1;
      wr_addr = 5'd0;
      wr_data = 32'hFFFFFFFF;
      rd_addr = {5'd0, 5'd0};
      #1;
      chk("zero_byp", rd_data, 64'd0);
      tick;
      wr_en = 1'b0;
      #1;
      chk("zero_wr", rd_data, 64'd0);

      wr_en   = 1'b1;
      wr_addr = 5'd9;
      wr_data = 32'h99999999;
      wr_be   = 4'hf;
      clr_req = 1'b1;
      #1;
      chk("coll_ack", 64'(wr_ack), 64'd0);
      chk("coll_busy", 64'(busy), 64'd0);
      tick;
      clr_req = 1'b0;
      wr_en   = 1'b0;
      rd_addr = {5'd5, 5'd9};
      #1;
      for (int c = 0; c < 32; c++) begin
         chk("req_busy", 64'(busy), 64'd1);
         chk("req_rd", rd_data, 64'd0);
         clr_req = (c == 5);
         tick;
         #1;
      end
      clr_req = 1'b0;
      chk("req_done", 64'(busy), 64'd0);
      chk("coll_e9", 64'(rd_data[31:0]), 64'd0);
      chk("coll_e5", 64'(rd_data[63:32]), 64'd0);

      wr_en   = 1'b1;
      wr_addr = 5'd4;
      wr_data = 32'h44;
      tick;
      wr_en   = 1'b0;
      clr_req = 1'b1;
      tick;
      clr_req = 1'b0;
      repeat (10) tick;
      reset_n = 1'b0;
      #1;
      chk("abort_busy", 64'(busy), 64'd1);
      chk("abort_ack", 64'(wr_ack), 64'd0);
      tick;
      tick;
      reset_n = 1'b1;
      cnt = 0;
      while (busy && cnt < 100) begin
         tick;
         cnt++;
      end
      chk("restart_len", 64'(cnt), 64'd32);
      rd_addr = {5'd4, 5'd7};
      #1;
      chk("restart_e4", 64'(rd_data[63:32]), 64'd0);
      chk("restart_e7", 64'(rd_data[31:0]), 64'd0);

      wr_en   = 1'b1;
      wr_addr = 5'd7;
      wr_data = 32'h77;
      tick;
      wr_en = 1'b0;
      #1;
      chk("post_wr", 64'(rd_data[31:0]), 64'h77);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/regbank_mp.md
# regbank_mp

Parametrised multi-read-port register bank, the successor to the fixed 32×32, 2-read/1-write bank. Adds configurable width, depth and read-port count, byte-enabled writes, optional write-to-read bypass, an optional hardwired-zero register 0, and a hardware clear sequencer. The sequencer zeroes the array one entry per cycle after reset or on request, so the storage array carries no reset. Sits between decode (register addresses) and execute (operands, writeback) in the datapath.

## Interface
- DATA_W, 32: register width in bits; must be a multiple of 8.
- ADDR_W, 5: address width; DEPTH = 2**ADDR_W entries.
- NRD, 2: number of read ports, 1..4.
- BYPASS, 1: 1 = a same-cycle accepted write is forwarded to matching read ports.
- ZERO_REG, 1: 1 = entry 0 always reads 0, and writes to it are accepted but discarded.
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- rd_addr  in  NRD*ADDR_W  packed read addresses; port i occupies bits [i*ADDR_W +: ADDR_W].
- rd_data  out  NRD*DATA_W  packed read data; port i occupies bits [i*DATA_W +: DATA_W]; combinational.
- wr_en  in  1  write request.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- wr_be  in  DATA_W/8  byte enables; bit b covers byte [8b+7:8b].
- wr_ack  out  1  write accepted this cycle; combinational.
- clr_req  in  1  single-cycle pulse that starts a full clear.
- busy  out  1  clear sequence in progress.

## Operation
- FSM states: CLEAR, IDLE.
- Reset (reset_n low) forces state = CLEAR and clear index = 0. busy = 1 immediately (asynchronously); rd_data = 0 and wr_ack = 0 while reset is asserted.
- CLEAR, each cycle: array[idx] <= 0 and idx <= idx + 1.
  - When idx == DEPTH-1, go to IDLE.
  - idx is ADDR_W bits wide; the terminal compare occurs before wrap-around.
- IDLE → CLEAR when clr_req = 1; idx restarts at 0.
- clr_req during CLEAR is ignored; the sequence does not restart.
- wr_ack = wr_en & (state == IDLE) & ~clr_req.
  - A write in the same cycle as clr_req is dropped.
  - A dropped write is not queued.
- Accepted write: for each b with wr_be[b] = 1, array[wr_addr] byte b <= wr_data byte b. Other bytes are held.
- Read port i:
  - ZERO_REG and rd_addr_i == 0: result is 0.
  - Else, state == CLEAR: result is 0.
  - Else, BYPASS and wr_ack and wr_addr == rd_addr_i: result is the merged value. Enabled bytes come from wr_data; the rest come from the array.
  - Otherwise: result is array[rd_addr_i].
- All read ports are independent; any number may alias the same address.

## Timing
- Write latency: data is visible through the array on the cycle after the accepting edge. With BYPASS = 1 it is also visible in the same cycle.
- Read latency: 0 cycles (combinational from rd_addr).
- After reset_n rises, busy stays high for exactly DEPTH rising edges, then falls. The first write can be accepted on cycle DEPTH.
- After clr_req is sampled in IDLE, busy rises on the next edge and stays high for DEPTH cycles.
- A reset asserted mid-clear aborts the sequence. The clear restarts from index 0 after release.
- Reset value of every output:
  - busy = 1
  - wr_ack = 0
  - rd_data = 0

## Structure
- Package regbank_pkg holds:
  - state typedef {CLEAR, IDLE};
  - default localparams for DATA_W and ADDR_W;
  - a function for byte-merge (old, new, be).
- Sub-module regbank_clr_seq: FSM plus clear index counter.
  - Outputs: busy, clr_we, clr_idx.
  - The top level muxes clr_we/clr_idx against the accepted write port.
- Storage array: no reset; inferred RAM-style, with one write port and NRD asynchronous read ports.

## Test plan
- Post-reset clear:
  - Stimulus: release reset_n; hold wr_en = 1 with wr_addr = 3.
  - Required: busy = 1 for 32 cycles; wr_ack = 0 throughout; all reads = 0. On cycle 32, busy = 0 and wr_ack = 1.
- Fill and read:
  - Stimulus: write entry k = 10*k for k = 0..31 with full byte enables; then read pairs (k, k+1) on ports 0 and 1.
  - Required: reg[0] = 0 (ZERO_REG); reg[k] = 10*k for k ≥ 1.
- Byte enables:
  - Stimulus: entry 5 = 0x11223344; write 0xAABBCCDD with wr_be = 4'b0101.
  - Required: entry 5 = 0x11BB33DD.
- Bypass:
  - Stimulus: BYPASS = 1; write 0xDEADBEEF to entry 7 while rd_addr0 = 7.
  - Required: rd_data0 = 0xDEADBEEF in the same cycle. With BYPASS = 0, rd_data0 shows the old value in that cycle.
- Clear collision and restart:
  - Stimulus: clr_req together with wr_en to entry 9.
  - Required: wr_ack = 0; entry 9 = 0 after the clear completes.
  - Stimulus: pulse reset_n low at clear cycle 10.
  - Required: busy lasts a further 32 cycles after release.
- Parameter sweep:
  - Configuration: DATA_W = 16, ADDR_W = 3, NRD = 4.
  - Required: the post-reset clear takes 8 cycles; all 4 ports read correctly from 4 distinct addresses simultaneously.
